// File: rtl/food_placer.sv
// food_placer: rejection-samples a free grid cell for food placement via an occupancy query.
// Optional FOOD_RETRY_LIMIT_EN macro bounds retries to MAX_TRIES and pulses fail on abort.
module food_placer #(
    parameter int RAND_W     = 9,
    parameter int X_CELLS    = 40,
    parameter int Y_CELLS    = 30,
    parameter int IDX_W      = 6,
    parameter int CELL_SHIFT = 4,
    parameter int X_ORG      = 0,
    parameter int Y_ORG      = 0,
    parameter int RST_CX     = 19,
    parameter int RST_CY     = 18,
    parameter int MAX_TRIES  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAND_W-1:0] rand_num,
    input  logic              req,
    input  logic              occ_hit,
    output logic [9:0]        occ_x,
    output logic [9:0]        occ_y,
    output logic [9:0]        food_x,
    output logic [9:0]        food_y,
    output logic              busy,
    output logic              done,
    output logic              fail
);
    typedef enum logic [2:0] {IDLE, SX, SY, CHK, COMMIT} state_t;
    state_t state;
    logic [IDX_W-1:0] idx, cx, cy;
    logic x_ok, y_ok, searching, limit;
    logic unused_rand;
    assign unused_rand = ^rand_num;
    assign idx = rand_num[IDX_W-1:0];
    assign x_ok = 32'(idx) < X_CELLS;
    assign y_ok = 32'(idx) < Y_CELLS;
    assign searching = state == SX || state == SY || state == CHK;
    assign occ_x = 10'(X_ORG) + 10'(32'(cx) << CELL_SHIFT);
    assign occ_y = 10'(Y_ORG) + 10'(32'(cy) << CELL_SHIFT);
`ifdef FOOD_RETRY_LIMIT_EN
    localparam int TW = $clog2(MAX_TRIES + 1);
    logic [TW-1:0] tries;
    logic reject;
    assign limit = tries >= TW'(MAX_TRIES);
    assign reject = (state == SX && !x_ok) || (state == SY && !y_ok) || (state == CHK && occ_hit);
    always_ff @(posedge clk) begin
        fail <= !rst && searching && limit;
        if (rst || state == IDLE)
            tries <= '0;
        else if (reject && !limit)
            tries <= tries + 1'b1;
    end
`else
    assign limit = 1'b0;
    assign fail = 1'b0;
`endif
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cx     <= IDX_W'(RST_CX);
            cy     <= IDX_W'(RST_CY);
            food_x <= 10'(X_ORG) + 10'(RST_CX << CELL_SHIFT);
            food_y <= 10'(Y_ORG) + 10'(RST_CY << CELL_SHIFT);
        end else if (searching && limit) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state <= SX;
                    busy  <= 1'b1;
                end
                SX: if (x_ok) begin
                    cx    <= idx;
                    state <= SY;
                end
                SY: if (y_ok) begin
                    cy    <= idx;
                    state <= CHK;
                end
                CHK: if (occ_hit) state <= SX;
                else begin
                    food_x <= occ_x;
                    food_y <= occ_y;
                    done   <= 1'b1;
                    state  <= COMMIT;
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: directed plus randomized checks of food_placer against a cycle-level placement model.
module tb_food_placer;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, occ_hit = 1'b0;
    logic [8:0] rand_num = '0;
    logic [9:0] occ_x, occ_y, food_x, food_y;
    logic busy, done, fail;
    int n_checks = 0, n_pass = 0;
    // model: phase 0 idle, 1 picking x, 2 picking y, 3 checking, 4 committing
    int phase = 0, mcx = 19, mcy = 18, mfx = 304, mfy = 288, mtries = 0, mfail = 0;

    food_placer dut (
        .clk(clk), .rst(rst), .rand_num(rand_num), .req(req), .occ_hit(occ_hit),
        .occ_x(occ_x), .occ_y(occ_y), .food_x(food_x), .food_y(food_y),
        .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int r, input bit rq, input bit hit, input bit rs);
        int idx;
        rand_num = 9'(r);
        req = rq;
        occ_hit = hit;
        rst = rs;
        idx = r % 64;
        mfail = 0;
        if (rs) begin
            phase = 0; mcx = 19; mcy = 18; mfx = 304; mfy = 288; mtries = 0;
        end
`ifdef FOOD_RETRY_LIMIT_EN
        else if (phase >= 1 && phase <= 3 && mtries >= 64) begin
            phase = 0; mfail = 1;
        end
`endif
        else if (phase == 0) begin
            if (rq) begin phase = 1; mtries = 0; end
        end else if (phase == 1) begin
            if (idx < 40) begin mcx = idx; phase = 2; end else mtries++;
        end else if (phase == 2) begin
            if (idx < 30) begin mcy = idx; phase = 3; end else mtries++;
        end else if (phase == 3) begin
            if (hit) begin phase = 1; mtries++; end
            else begin mfx = mcx * 16; mfy = mcy * 16; phase = 4; end
        end else phase = 0;
        @(posedge clk);
        @(negedge clk);
        check("busy", busy, phase != 0);
        check("done", done, phase == 4);
        check("fail", fail, mfail);
        check("food_x", food_x, mfx);
        check("food_y", food_y, mfy);
        check("occ_x", occ_x, mcx * 16);
        check("occ_y", occ_y, mcy * 16);
    endtask

    initial begin
        @(negedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_food_x", food_x, 304);
        check("rst_food_y", food_y, 288);
        check("rst_busy", busy, 0);
        // happy path: done four cycles after req
        step(0, 1, 0, 0);
        step(5, 0, 0, 0);
        step(7, 0, 0, 0);
        check("happy_occ_x", occ_x, 80);
        check("happy_occ_y", occ_y, 112);
        step(0, 0, 0, 0);
        check("happy_done", done, 1);
        check("happy_food_x", food_x, 80);
        check("happy_food_y", food_y, 112);
        step(0, 0, 0, 0);
        // range rejection in both axes
        step(0, 1, 0, 0);
        step(45, 0, 0, 0);
        step(63, 0, 0, 0);
        check("range_busy", busy, 1);
        step(12, 0, 0, 0);
        step(30, 0, 0, 0);
        step(29, 0, 0, 0);
        check("range_occ_x", occ_x, 192);
        check("range_occ_y", occ_y, 464);
        step(0, 0, 0, 0);
        check("range_food_y", food_y, 464);
        step(0, 0, 0, 0);
        // occupied first candidate forces a second pick
        step(0, 1, 0, 0);
        step(3, 0, 0, 0);
        step(3, 0, 0, 0);
        step(0, 0, 1, 0);
        check("occ_food_held", food_x, 192);
        step(4, 0, 0, 0);
        step(4, 0, 0, 0);
        step(0, 0, 0, 0);
        check("occ_food_x", food_x, 64);
        check("occ_food_y", food_y, 64);
        step(0, 0, 0, 0);
        check("occ_single_done", done, 0);
        // req during SY and COMMIT must not start another placement
        step(0, 1, 0, 0);
        step(10, 0, 0, 0);
        step(11, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("edge_idle", busy, 0);
        // reset while checking aborts silently
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(2, 0, 0, 0);
        step(0, 0, 0, 1);
        check("rst_chk_food_x", food_x, 304);
        check("rst_chk_done", done, 0);
`ifdef FOOD_RETRY_LIMIT_EN
        step(0, 1, 0, 0);
        for (int i = 0; i < 80 && !fail; i++) step(63, 0, 0, 0);
        check("limit_fail", fail, 1);
        check("limit_busy", busy, 0);
        check("limit_food", food_x, 304);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("limit_recover", done, 1);
`endif
        for (int i = 0; i < 3000; i++)
            step($urandom % 512, ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 200) == 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 The block SHALL take parameter RAND_W, default 9, as the width of the random input.
REQ-002 The block SHALL take parameter X_CELLS, default 40, as the number of grid columns.
REQ-003 The block SHALL take parameter Y_CELLS, default 30, as the number of grid rows.
REQ-004 The block SHALL take parameter IDX_W, default 6, as the candidate index width, sliced from rand_num[IDX_W-1:0]; IDX_W <= RAND_W.
REQ-005 The block SHALL take parameter CELL_SHIFT, default 4, as log2 of cell size in pixels (16 px).
REQ-006 The block SHALL take parameter X_ORG / Y_ORG, default 0 / 0, as the pixel origin of the play field.
REQ-007 The block SHALL take parameter RST_CX / RST_CY, default 19 / 18, as the reset cell (pixel 304 / 288).
REQ-008 The block SHALL take parameter MAX_TRIES, default 64, as the rejection limit (used only with the macro of REQ-024).
REQ-009 The block SHALL run on one clock, with a synchronous, active-high reset.
REQ-010 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rand_num  in  RAND_W  free-running random value
- req  in  1  placement request pulse
- occ_hit  in  1  combinational reply: occ_x/occ_y lies on the snake
- occ_x  out  10  candidate pixel x for the occupancy query
- occ_y  out  10  candidate pixel y for the occupancy query
- food_x  out  10  committed food pixel x
- food_y  out  10  committed food pixel y
- busy  out  1  high when the FSM is not in IDLE
- done  out  1  one-cycle pulse on commit
- fail  out  1  one-cycle pulse on abort

Function
REQ-011 The FSM SHALL have states IDLE, SX, SY, CHK and COMMIT, all registered.
REQ-012 IDLE: on req=1, the FSM SHALL go to SX and clear the retry counter; otherwise it SHALL stay in IDLE.
REQ-013 SX: if idx=rand_num[IDX_W-1:0] < X_CELLS, the block SHALL store cx=idx and go to SY; otherwise it SHALL increment the retry counter and stay in SX.
REQ-014 SY: the same rule against Y_CELLS SHALL apply, storing cy and going to CHK on acceptance.
REQ-015 Candidate pixel coordinates SHALL be occ_x = X_ORG + (cx << CELL_SHIFT) and occ_y = Y_ORG + (cy << CELL_SHIFT), driven from registers and stable throughout CHK.
REQ-016 CHK: the block SHALL sample occ_hit in the same cycle. On 1, it SHALL increment the retry counter and go to SX. On 0, it SHALL load food_x/food_y from occ_x/occ_y at the clock edge and go to COMMIT.
REQ-017 COMMIT: done SHALL be 1 for exactly this cycle, and the FSM SHALL then go to IDLE.
REQ-018 Minimum latency SHALL be: req in cycle 0, done in cycle 4, with food_x/food_y already updated in cycle 4.
REQ-019 req while busy=1 SHALL be ignored, not queued; req in the COMMIT cycle SHALL also be ignored.
REQ-020 food_x/food_y SHALL change only on a CHK-to-COMMIT transition and SHALL otherwise hold.
REQ-021 The retry counter SHALL saturate at MAX_TRIES and never wrap.
REQ-022 done and fail SHALL never be high in the same cycle.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL enter IDLE and set:
- busy=0, done=0, fail=0, retry counter 0
- cx=RST_CX, cy=RST_CY
- food_x = X_ORG + (RST_CX << CELL_SHIFT) and food_y = Y_ORG + (RST_CY << CELL_SHIFT), i.e. 304/288 at defaults
- occ_x/occ_y equal to food_x/food_y

Reset mid-placement SHALL abort with no done or fail pulse.

Configuration
REQ-024 With FOOD_RETRY_LIMIT_EN defined, when the retry counter reaches MAX_TRIES in SX, SY or CHK, the FSM SHALL go to IDLE next cycle with fail=1 for one cycle and food_x/food_y unchanged.
REQ-025 Without FOOD_RETRY_LIMIT_EN, the block SHALL retry indefinitely, fail SHALL be tied 0, and the counter logic SHALL be absent.

Verification
REQ-026 Reset test: assert rst for 2 cycles -> food_x=304, food_y=288, busy=0, done=0, fail=0.
REQ-027 Happy path: req in cycle 0, rand_num=5 in cycle 1, rand_num=7 in cycle 2, occ_hit=0 -> occ=(80,112) in cycle 3, done=1 and food=(80,112) in cycle 4.
REQ-028 Range reject: rand_num=45,63,12 in SX -> stays in SX for two cycles, accepts cx=12 (x=192); SY with rand_num=30 rejected, 29 accepted (y=464).
REQ-029 Occupancy retry: first candidate (3,3) with occ_hit=1 -> returns to SX, food unchanged; second candidate (4,4) with occ_hit=0 -> food=(64,64), single done.
REQ-030 Retry limit: with FOOD_RETRY_LIMIT_EN defined, hold rand_num=63 -> fail pulse after 64 rejections, food unchanged, busy=0; a new req then succeeds normally.
REQ-031 Request and reset edges: req pulses in SY and COMMIT -> exactly one done; rst asserted in CHK -> IDLE, food=(304,288), no done.
